// File: rtl/icache_pkg.sv
// Shared instruction-cache geometry, refill FSM states and line-format helpers.
// The cache array and the refill controller both use these so the line layout cannot drift.
package icache_pkg;

    localparam int ICACHE_NFU     = 2;
    localparam int ICACHE_ENTRIES = 256;
    localparam int ICACHE_PAL     = 56;

    localparam int ICACHE_INDEXW  = $clog2(ICACHE_ENTRIES);
    localparam int ICACHE_OFFSETW = $clog2(ICACHE_NFU * 4);
    localparam int ICACHE_WORDSW  = ICACHE_NFU * 32;
    localparam int ICACHE_TAGW    = ICACHE_PAL - ICACHE_INDEXW - ICACHE_OFFSETW;
    localparam int ICACHE_LINEW   = ICACHE_WORDSW + 1 + ICACHE_TAGW;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_WRITE = 3'd3,
        ST_FLUSH = 3'd4
    } refill_state_t;

    // Present-line format: {word0..wordN-1, tag, valid}, word0 in the MSBs.
    function automatic logic [ICACHE_LINEW-1:0] pack_line(
        input logic [ICACHE_WORDSW-1:0] words,
        input logic [ICACHE_TAGW-1:0]   tag,
        input logic                     valid
    );
        return {words, tag, valid};
    endfunction

    function automatic logic [ICACHE_INDEXW-1:0] addr_index(input logic [ICACHE_PAL-1:0] addr);
        return addr[ICACHE_OFFSETW +: ICACHE_INDEXW];
    endfunction

    function automatic logic [ICACHE_TAGW-1:0] addr_tag(input logic [ICACHE_PAL-1:0] addr);
        return addr[ICACHE_PAL-1 -: ICACHE_TAGW];
    endfunction

endpackage

// File: rtl/icache_line_assembler.sv
// NFU x 32-bit word buffer that collects a cache line one memory word at a time.
// Slot 0 (lowest address) appears in the MSBs of the packed output.
module icache_line_assembler #(
    parameter int NFU   = 2,
    parameter int SLOTW = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              we,
    input  logic [SLOTW-1:0]  slot,
    input  logic [31:0]       data,
    output logic [NFU*32-1:0] words
);

    logic [31:0] buf_q [NFU];

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            for (int i = 0; i < NFU; i++) begin
                buf_q[i] <= '0;
            end
        end else if (we) begin
            buf_q[slot] <= data;
        end
    end

    always_comb begin
        words = '0;
        for (int i = 0; i < NFU; i++) begin
            words[(NFU-1-i)*32 +: 32] = buf_q[i];
        end
    end

endmodule

// File: rtl/icache_refill_ctrl.sv
// Instruction-cache refill sequencer: fetches a missing line word by word, writes it
// into the cache array, and walks every entry on a full invalidate.
//
// Handshakes: a miss transfers on a rising edge with miss_valid && miss_ready; a memory
// request transfers on an edge with mem_req_valid && mem_req_ready, and mem_req_valid /
// mem_req_addr hold stable until then; responses have no ready and are only consumed in
// WAIT, anything arriving elsewhere is dropped. At most one request is ever outstanding.
module icache_refill_ctrl
    import icache_pkg::*;
#(
    parameter int NFU                     = ICACHE_NFU,
    parameter int NCACHE_ENTRIES          = ICACHE_ENTRIES,
    parameter int PHYSICAL_ADDRESS_LENGTH = ICACHE_PAL,
    localparam int CACHEINDEX     = $clog2(NCACHE_ENTRIES),
    localparam int CACHELINESIZE  = NFU * 32,
    localparam int CACHELINEINDEX = $clog2(NFU * 4),
    localparam int TAGSIZE        = PHYSICAL_ADDRESS_LENGTH - CACHEINDEX - CACHELINEINDEX,
    localparam int LINEW          = CACHELINESIZE + 1 + TAGSIZE
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               miss_valid,
    input  logic [PHYSICAL_ADDRESS_LENGTH-1:0] miss_address,
    output logic                               miss_ready,
    input  logic                               invalidate_all,
    output logic                               mem_req_valid,
    output logic [PHYSICAL_ADDRESS_LENGTH-1:0] mem_req_addr,
    input  logic                               mem_req_ready,
    input  logic                               mem_resp_valid,
    input  logic [31:0]                        mem_resp_data,
    input  logic                               mem_resp_error,
    output logic                               fill_we,
    output logic [CACHEINDEX-1:0]              fill_index,
    output logic [LINEW-1:0]                   fill_line,
    output logic                               fill_done,
    output logic                               fill_error,
    output logic                               busy,
    output refill_state_t                      dbg_state
);

    localparam int SLOTW = (NFU > 1) ? $clog2(NFU) : 1;
    localparam logic [CACHEINDEX-1:0] LAST_WORD  = CACHEINDEX'(NFU - 1);
    localparam logic [CACHEINDEX-1:0] LAST_ENTRY = CACHEINDEX'(NCACHE_ENTRIES - 1);

    refill_state_t state, state_nx;

    // Shared counter: word slot during a refill, entry index during a flush.
    logic [CACHEINDEX-1:0]              cnt;
    logic                               flush_pending;
    logic                               err_q;
    logic [PHYSICAL_ADDRESS_LENGTH-1:0] base_q;
    logic [CACHEINDEX-1:0]              index_q;
    logic [TAGSIZE-1:0]                 tag_q;
    logic [CACHELINESIZE-1:0]           words;

    logic ready_int;
    logic accept;
    logic resp_ok;
    logic resp_err;
    logic last_word;
    logic flush_last;

    always_comb begin
        ready_int  = !rst && (state == ST_IDLE) && !flush_pending && !invalidate_all;
        accept     = miss_valid && ready_int;
        resp_ok    = (state == ST_WAIT) && mem_resp_valid && !mem_resp_error;
        resp_err   = (state == ST_WAIT) && mem_resp_valid && mem_resp_error;
        last_word  = (cnt == LAST_WORD);
        flush_last = (cnt == LAST_ENTRY);
        state_nx   = state;
        case (state)
            ST_IDLE: begin
                if (invalidate_all || flush_pending) begin
                    state_nx = ST_FLUSH;
                end else if (accept) begin
                    state_nx = ST_REQ;
                end
            end
            ST_REQ: begin
                if (mem_req_ready) begin
                    state_nx = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (resp_err) begin
                    state_nx = ST_IDLE;
                end else if (resp_ok) begin
                    state_nx = last_word ? ST_WRITE : ST_REQ;
                end
            end
            ST_WRITE: begin
                state_nx = (flush_pending || invalidate_all) ? ST_FLUSH : ST_IDLE;
            end
            ST_FLUSH: begin
                if (flush_last) begin
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            flush_pending <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state <= state_nx;
            err_q <= resp_err;

            if (accept || state == ST_WRITE || (state == ST_IDLE && state_nx == ST_FLUSH)) begin
                cnt <= '0;
            end else if (resp_ok && !last_word) begin
                cnt <= cnt + 1'b1;
            end else if (state == ST_FLUSH) begin
                cnt <= flush_last ? '0 : cnt + 1'b1;
            end

            // An invalidate seen mid-refill is remembered and honoured once the line lands.
            if (state == ST_FLUSH && flush_last) begin
                flush_pending <= 1'b0;
            end else if (invalidate_all && state != ST_IDLE && state != ST_FLUSH) begin
                flush_pending <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            base_q  <= {miss_address[PHYSICAL_ADDRESS_LENGTH-1:CACHELINEINDEX], CACHELINEINDEX'(0)};
            index_q <= addr_index(miss_address);
            tag_q   <= addr_tag(miss_address);
        end
    end

    icache_line_assembler #(
        .NFU   (NFU),
        .SLOTW (SLOTW)
    ) u_assembler (
        .clk   (clk),
        .rst   (rst),
        .clear (accept),
        .we    (resp_ok),
        .slot  (cnt[SLOTW-1:0]),
        .data  (mem_resp_data),
        .words (words)
    );

    // Every output is forced low while reset is held, including the registered pulses.
    always_comb begin
        miss_ready    = ready_int;
        mem_req_valid = !rst && (state == ST_REQ);
        mem_req_addr  = '0;
        if (mem_req_valid) begin
            mem_req_addr = base_q + PHYSICAL_ADDRESS_LENGTH'({cnt[SLOTW-1:0], 2'b00});
        end
        fill_we    = !rst && (state == ST_WRITE || state == ST_FLUSH);
        fill_done  = !rst && (state == ST_WRITE);
        fill_index = '0;
        fill_line  = '0;
        if (fill_done) begin
            fill_index = index_q;
            fill_line  = pack_line(words, tag_q, 1'b1);
        end else if (fill_we) begin
            fill_index = cnt;
        end
        fill_error = !rst && err_q;
        busy       = !rst && (state != ST_IDLE);
        dbg_state  = rst ? ST_IDLE : state;
    end

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Directed bench for icache_refill_ctrl: refill timing, back-pressure, bus error,
// invalidate interactions and reset abandonment, with hand-computed expectations.
module tb_icache_refill_ctrl;
    import icache_pkg::*;

    localparam int PAL = 56;
    localparam int IW  = 8;
    localparam int LW  = 110;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            miss_valid = 1'b0;
    logic [PAL-1:0]  miss_address = '0;
    logic            miss_ready;
    logic            invalidate_all = 1'b0;
    logic            mem_req_valid;
    logic [PAL-1:0]  mem_req_addr;
    logic            mem_req_ready = 1'b0;
    logic            mem_resp_valid = 1'b0;
    logic [31:0]     mem_resp_data = '0;
    logic            mem_resp_error = 1'b0;
    logic            fill_we;
    logic [IW-1:0]   fill_index;
    logic [LW-1:0]   fill_line;
    logic            fill_done;
    logic            fill_error;
    logic            busy;
    refill_state_t   dbg_state;

    always #5 clk = ~clk;

    icache_refill_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .miss_valid     (miss_valid),
        .miss_address   (miss_address),
        .miss_ready     (miss_ready),
        .invalidate_all (invalidate_all),
        .mem_req_valid  (mem_req_valid),
        .mem_req_addr   (mem_req_addr),
        .mem_req_ready  (mem_req_ready),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data),
        .mem_resp_error (mem_resp_error),
        .fill_we        (fill_we),
        .fill_index     (fill_index),
        .fill_line      (fill_line),
        .fill_done      (fill_done),
        .fill_error     (fill_error),
        .busy           (busy),
        .dbg_state      (dbg_state)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Monitor logs, filled on falling edges.
    int             cyc = 0;
    logic [PAL-1:0] exp_q[$];
    logic [PAL-1:0] acc_addr_q[$];
    int             acc_cyc_q[$];
    logic [IW-1:0]  we_idx_q[$];
    logic [LW-1:0]  we_line_q[$];
    logic           we_done_q[$];
    int             we_cyc_q[$];
    int             err_cnt = 0;
    int             accept_cyc = 0;
    int             unstable_cnt = 0;
    logic           prev_valid = 1'b0;
    logic           prev_ready = 1'b0;
    logic [PAL-1:0] prev_addr = '0;

    always @(negedge clk) begin
        cyc++;
        if (prev_valid && !prev_ready && (!mem_req_valid || mem_req_addr !== prev_addr)) unstable_cnt++;
        prev_valid = mem_req_valid;
        prev_ready = mem_req_ready;
        prev_addr  = mem_req_addr;
        if (mem_req_valid && mem_req_ready) begin
            acc_addr_q.push_back(mem_req_addr);
            acc_cyc_q.push_back(cyc);
        end
        if (fill_we) begin
            we_idx_q.push_back(fill_index);
            we_line_q.push_back(fill_line);
            we_done_q.push_back(fill_done);
            we_cyc_q.push_back(cyc);
        end
        if (fill_error) err_cnt++;
        if (miss_valid && miss_ready) accept_cyc = cyc;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        exp_q.delete();
        acc_addr_q.delete();
        acc_cyc_q.delete();
        we_idx_q.delete();
        we_line_q.delete();
        we_done_q.delete();
        we_cyc_q.delete();
        err_cnt = 0;
        unstable_cnt = 0;
    endtask

    // Called while the controller sits in REQ; returns just after the response edge.
    task automatic serve_word(input logic [31:0] data, input logic err, input int stall, input int delay);
        mem_req_ready = 1'b0;
        repeat (stall) tick();
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        repeat (delay) tick();
        mem_resp_valid = 1'b1;
        mem_resp_data  = data;
        mem_resp_error = err;
        tick();
        mem_resp_valid = 1'b0;
        mem_resp_error = 1'b0;
        mem_resp_data  = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        miss_valid = 1'b1;
        repeat (2) tick();
        @(negedge clk);
        n_checks++;
        if ({miss_ready, mem_req_valid, fill_we, fill_done, fill_error, busy} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b expected 000000",
                     {miss_ready, mem_req_valid, fill_we, fill_done, fill_error, busy});
        end
        tick();
        rst = 1'b0;
        miss_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (miss_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: miss_ready=%b busy=%b expected 1 0", miss_ready, busy);
        end
    endtask

    task automatic test_single_miss();
        logic [LW-1:0] exp_line;
        exp_line = {32'hAAAA0001, 32'hBBBB0002, 45'h21, 1'b1};
        tick();
        clear_logs();
        miss_address = 56'h10A13;
        miss_valid = 1'b1;
        @(negedge clk);
        n_checks++;
        if (miss_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL single_ready: got %b expected 1", miss_ready);
        end
        tick();
        miss_valid = 1'b0;
        serve_word(32'hAAAA0001, 1'b0, 0, 0);
        serve_word(32'hBBBB0002, 1'b0, 0, 0);
        @(negedge clk);
        n_checks++;
        if (fill_we !== 1'b1 || fill_done !== 1'b1 || fill_index !== 8'h42 || fill_line !== exp_line) begin
            n_fail++;
            $display("FAIL single_write: we=%b done=%b idx=%h line=%h expected 1 1 42 %h",
                     fill_we, fill_done, fill_index, fill_line, exp_line);
        end
        tick();
        @(negedge clk);
        n_checks++;
        if (miss_ready !== 1'b1 || fill_we !== 1'b0 || fill_done !== 1'b0) begin
            n_fail++;
            $display("FAIL single_return: ready=%b we=%b done=%b expected 1 0 0", miss_ready, fill_we, fill_done);
        end
        n_checks++;
        if (acc_addr_q.size() != 2) begin
            n_fail++;
            $display("FAIL single_req_count: got %0d expected 2", acc_addr_q.size());
        end else if (acc_addr_q[0] !== 56'h10A10 || acc_addr_q[1] !== 56'h10A14) begin
            n_fail++;
            $display("FAIL single_req_addr: got %h %h expected 10a10 10a14", acc_addr_q[0], acc_addr_q[1]);
        end
        n_checks++;
        if (acc_cyc_q.size() != 2 || we_cyc_q.size() != 1) begin
            n_fail++;
            $display("FAIL single_timing: req=%0d we=%0d events expected 2 1", acc_cyc_q.size(), we_cyc_q.size());
        end else if (acc_cyc_q[0] != accept_cyc + 1 || acc_cyc_q[1] != accept_cyc + 3 ||
                     we_cyc_q[0] != accept_cyc + 5) begin
            n_fail++;
            $display("FAIL single_timing: offsets %0d %0d %0d expected 1 3 5", acc_cyc_q[0] - accept_cyc,
                     acc_cyc_q[1] - accept_cyc, we_cyc_q[0] - accept_cyc);
        end
    endtask

    task automatic test_back_pressure();
        logic [LW-1:0] exp_line;
        exp_line = {32'h11112222, 32'h33334444, 45'h2468A, 1'b1};
        tick();
        clear_logs();
        exp_q.push_back(56'h12345678);
        exp_q.push_back(56'h1234567C);
        miss_address = 56'h1234567C;
        miss_valid = 1'b1;
        tick();
        miss_valid = 1'b0;
        serve_word(32'h11112222, 1'b0, 3, 4);
        serve_word(32'h33334444, 1'b0, 3, 4);
        @(negedge clk);
        n_checks++;
        if (fill_we !== 1'b1 || fill_index !== 8'hCF || fill_line !== exp_line) begin
            n_fail++;
            $display("FAIL bp_write: we=%b idx=%h line=%h expected 1 cf %h", fill_we, fill_index, fill_line, exp_line);
        end
        repeat (3) tick();
        n_checks++;
        if (unstable_cnt != 0) begin
            n_fail++;
            $display("FAIL bp_stable: %0d unstable request cycles expected 0", unstable_cnt);
        end
        n_checks++;
        if (acc_addr_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL bp_req_count: got %0d expected %0d", acc_addr_q.size(), exp_q.size());
        end else if (acc_addr_q[0] !== exp_q[0] || acc_addr_q[1] !== exp_q[1]) begin
            n_fail++;
            $display("FAIL bp_req_addr: got %h %h expected %h %h", acc_addr_q[0], acc_addr_q[1], exp_q[0], exp_q[1]);
        end
        n_checks++;
        if (we_idx_q.size() != 1) begin
            n_fail++;
            $display("FAIL bp_we_count: got %0d expected 1", we_idx_q.size());
        end
    endtask

    task automatic test_error();
        tick();
        clear_logs();
        miss_address = 56'h400;
        miss_valid = 1'b1;
        tick();
        miss_valid = 1'b0;
        serve_word(32'h01020304, 1'b0, 0, 0);
        serve_word(32'h05060708, 1'b1, 0, 0);
        @(negedge clk);
        n_checks++;
        if (fill_error !== 1'b1 || miss_ready !== 1'b1 || fill_we !== 1'b0) begin
            n_fail++;
            $display("FAIL err_pulse: error=%b ready=%b we=%b expected 1 1 0", fill_error, miss_ready, fill_we);
        end
        tick();
        @(negedge clk);
        n_checks++;
        if (fill_error !== 1'b0) begin
            n_fail++;
            $display("FAIL err_one_cycle: got %b expected 0", fill_error);
        end
        n_checks++;
        if (we_idx_q.size() != 0 || err_cnt != 1) begin
            n_fail++;
            $display("FAIL err_no_write: writes=%0d pulses=%0d expected 0 1", we_idx_q.size(), err_cnt);
        end
    endtask

    task automatic test_invalidate_during_refill();
        logic [LW-1:0] exp_line;
        int bad_ready;
        int bad_entries;
        bit finished;
        exp_line = {32'hCAFE0000, 32'hCAFE0004, 45'h21, 1'b1};
        bad_ready = 0;
        bad_entries = 0;
        finished = 1'b0;
        tick();
        clear_logs();
        miss_address = 56'h10A13;
        miss_valid = 1'b1;
        tick();
        miss_valid = 1'b0;
        serve_word(32'hCAFE0000, 1'b0, 0, 0);
        invalidate_all = 1'b1;
        @(negedge clk);
        if (miss_ready) bad_ready++;
        tick();
        invalidate_all = 1'b0;
        serve_word(32'hCAFE0004, 1'b0, 0, 0);
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (!busy) begin
                finished = 1'b1;
                break;
            end
            if (miss_ready) bad_ready++;
            tick();
        end
        n_checks++;
        if (!finished || miss_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL inv_complete: finished=%b ready=%b expected 1 1", finished, miss_ready);
        end
        n_checks++;
        if (bad_ready != 0) begin
            n_fail++;
            $display("FAIL inv_ready_low: %0d cycles with miss_ready high expected 0", bad_ready);
        end
        n_checks++;
        if (we_idx_q.size() != 257) begin
            n_fail++;
            $display("FAIL inv_write_count: got %0d expected 257", we_idx_q.size());
        end else begin
            if (we_idx_q[0] !== 8'h42 || we_line_q[0] !== exp_line || we_done_q[0] !== 1'b1) begin
                n_fail++;
                $display("FAIL inv_line_first: idx=%h line=%h done=%b expected 42 %h 1",
                         we_idx_q[0], we_line_q[0], we_done_q[0], exp_line);
            end
            for (int i = 1; i < 257; i++) begin
                if (we_idx_q[i] !== IW'(i - 1) || we_line_q[i] !== '0 || we_done_q[i] !== 1'b0 ||
                    we_cyc_q[i] != we_cyc_q[i-1] + 1) bad_entries++;
            end
            n_checks++;
            if (bad_entries != 0) begin
                n_fail++;
                $display("FAIL inv_flush_walk: %0d bad flush writes expected 0", bad_entries);
            end
        end
    endtask

    task automatic test_miss_and_invalidate();
        logic [LW-1:0] exp_line;
        bit accepted;
        exp_line = {32'h00000005, 32'h00000006, 45'h1, 1'b1};
        accepted = 1'b0;
        tick();
        clear_logs();
        miss_address = 56'h808;
        miss_valid = 1'b1;
        invalidate_all = 1'b1;
        @(negedge clk);
        n_checks++;
        if (miss_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL simul_priority: miss_ready=%b expected 0", miss_ready);
        end
        tick();
        invalidate_all = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (miss_ready) begin
                accepted = 1'b1;
                break;
            end
            tick();
        end
        n_checks++;
        if (!accepted || we_idx_q.size() != 256) begin
            n_fail++;
            $display("FAIL simul_flush_first: accepted=%b writes_before=%0d expected 1 256", accepted, we_idx_q.size());
        end
        tick();
        miss_valid = 1'b0;
        serve_word(32'h00000005, 1'b0, 0, 0);
        serve_word(32'h00000006, 1'b0, 0, 0);
        @(negedge clk);
        n_checks++;
        if (fill_we !== 1'b1 || fill_index !== 8'h01 || fill_line !== exp_line) begin
            n_fail++;
            $display("FAIL simul_miss_write: we=%b idx=%h line=%h expected 1 01 %h", fill_we, fill_index, fill_line, exp_line);
        end
    endtask

    task automatic test_reset_mid_refill();
        tick();
        clear_logs();
        miss_address = 56'h10A13;
        miss_valid = 1'b1;
        tick();
        miss_valid = 1'b0;
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({miss_ready, mem_req_valid, fill_we, fill_done, fill_error, busy} !== 6'b0 ||
            mem_req_addr !== '0 || fill_index !== '0 || fill_line !== '0) begin
            n_fail++;
            $display("FAIL rst_mid_outputs: flags=%b addr=%h idx=%h expected 000000 0 0",
                     {miss_ready, mem_req_valid, fill_we, fill_done, fill_error, busy}, mem_req_addr, fill_index);
        end
        tick();
        @(negedge clk);
        n_checks++;
        if ({miss_ready, mem_req_valid, fill_we, fill_done, fill_error, busy} !== 6'b0) begin
            n_fail++;
            $display("FAIL rst_hold_outputs: got %b expected 000000",
                     {miss_ready, mem_req_valid, fill_we, fill_done, fill_error, busy});
        end
        tick();
        rst = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'hDEADBEEF;
        tick();
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
        @(negedge clk);
        n_checks++;
        if (miss_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_stray_resp: ready=%b busy=%b expected 1 0", miss_ready, busy);
        end
        repeat (3) tick();
        n_checks++;
        if (we_idx_q.size() != 0 || err_cnt != 0 || acc_addr_q.size() != 1) begin
            n_fail++;
            $display("FAIL rst_abandon: writes=%0d errors=%0d requests=%0d expected 0 0 1",
                     we_idx_q.size(), err_cnt, acc_addr_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_single_miss();
        test_back_pressure();
        test_error();
        test_invalidate_during_refill();
        test_miss_and_invalidate();
        test_reset_mid_refill();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/icache_refill_ctrl.md
Name: icache_refill_ctrl

Overview:
- Sequences instruction-cache miss handling. Accepts a miss, fetches the full line from memory one 32-bit word at a time, assembles it, then issues a single line write into the cache array in the standard present-line format {data, tag, valid}.
- Also sequences a full-cache invalidate by walking every entry.
- Sits between the instruction cache miss output / write port and the memory request channel.

Parameters:
- NFU, 2: functional units; line = NFU 32-bit words.
- NCACHE_ENTRIES, 256: cache lines; CACHEINDEX = $clog2(NCACHE_ENTRIES).
- PHYSICAL_ADDRESS_LENGTH, 56: address width.
- Derived: CACHELINESIZE = NFU*32; CACHELINEINDEX = $clog2(NFU*4); TAGSIZE = PHYSICAL_ADDRESS_LENGTH-CACHEINDEX-CACHELINEINDEX; LINEW = CACHELINESIZE+1+TAGSIZE.

Ports:
- Clocking (one clock; reset is synchronous and active-high):
  - clk  in  1  sole clock, rising edge
  - rst  in  1  synchronous active-high reset
- Miss interface:
  - miss_valid  in  1  cache reports miss
  - miss_address  in  PHYSICAL_ADDRESS_LENGTH  missing fetch address
  - miss_ready  out  1  controller accepts miss this cycle
- Invalidate interface:
  - invalidate_all  in  1  request full invalidate (level; sampled when accepted)
- Memory request channel:
  - mem_req_valid  out  1  word read request
  - mem_req_addr  out  PHYSICAL_ADDRESS_LENGTH  word byte address
  - mem_req_ready  in  1  memory accepts request
- Memory response channel:
  - mem_resp_valid  in  1  read data valid
  - mem_resp_data  in  32  read word
  - mem_resp_error  in  1  bus error with response
- Cache fill port:
  - fill_we  out  1  cache line write strobe
  - fill_index  out  CACHEINDEX  line index written
  - fill_line  out  LINEW  {word0..wordNFU-1, tag, valid}; word0 (lowest address) in the MSBs
- Status:
  - fill_done  out  1  one-cycle pulse: line written, fetch may retry
  - fill_error  out  1  one-cycle pulse: refill aborted
  - busy  out  1  state != IDLE

Behaviour:
- States: IDLE, REQ, WAIT, WRITE, FLUSH.
- Reset:
  - While rst is high: state IDLE, word counter 0, flush_pending 0.
  - While rst is high, all outputs are 0, including miss_ready.
  - First cycle after reset: miss_ready = 1.
- miss_ready = (state==IDLE) && !flush_pending && !invalidate_all. Miss is accepted on an edge with miss_valid && miss_ready.
- On accept, latch:
  - base = miss_address with low CACHELINEINDEX bits cleared
  - index = address[CACHELINEINDEX+:CACHEINDEX]
  - tag = top TAGSIZE bits
  - k = 0
  - Go to REQ.
- REQ:
  - mem_req_valid = 1, mem_req_addr = base + 4*k, held stable until mem_req_ready.
  - mem_req_ready → WAIT.
- WAIT:
  - mem_resp_valid && !error: store data in slot k. If k == NFU-1 → WRITE; else k++ → REQ.
  - mem_resp_valid && error: fill_error pulses next cycle, no cache write, → IDLE.
- WRITE (exactly one cycle):
  - fill_we = 1, fill_done = 1.
  - fill_index = latched index; fill_line = {words, tag, 1'b1}.
  - Then → IDLE, or → FLUSH if flush_pending.
- Responses arriving outside WAIT are ignored (dropped). Only one request is outstanding at a time.
- Latency:
  - Miss accepted at edge T; zero-wait memory (ready=1, response the cycle after acceptance).
  - Word k is requested in cycle T+1+2k.
  - fill_we/fill_done are asserted in cycle T+2*NFU+1.
  - miss_ready returns in cycle T+2*NFU+2.
- Invalidate:
  - invalidate_all in IDLE → FLUSH with counter 0.
  - invalidate_all during a refill sets flush_pending. The refill completes normally, then FLUSH starts.
  - In IDLE, invalidate_all has priority over simultaneous miss_valid (miss_ready = 0).
  - FLUSH writes fill_we = 1, fill_index = counter, fill_line = 0 for NCACHE_ENTRIES consecutive cycles. Counter wraps at NCACHE_ENTRIES-1 → IDLE, clear flush_pending.
  - No fill_done pulse for a flush.
- Reset mid-operation abandons the refill or flush: no fill_we, no fill_done, no fill_error. Any later stray response is dropped.
- fill_index and fill_line are don't-care when fill_we = 0; the bench checks them only on fill_we.

Decomposition:
- icache_pkg holds:
  - derived width localparams
  - state enum
  - pack_line(words, tag, valid) function
  - addr_index()/addr_tag() extraction functions
- The instruction cache uses the same package so the split stays consistent.
- One sub-module: icache_line_assembler, an NFU×32 word buffer with slot write-enable and clear.

Test Plan:
- Single miss, zero-wait memory:
  - Stimulus (NFU=2, defaults): miss_address 56'h10A13; responses 32'hAAAA0001, 32'hBBBB0002.
  - Required: requests at 56'h10A10 then 56'h10A14.
  - Required in cycle T+5: fill_we = 1, fill_index = 8'h42, fill_line = {32'hAAAA0001, 32'hBBBB0002, 45'h21, 1'b1}, fill_done = 1.
- Back-pressure:
  - Stimulus: mem_req_ready low 3 cycles; response delayed 4 cycles.
  - Required: mem_req_valid/addr stable throughout; exactly 2 requests; single fill_we.
- Error:
  - Stimulus: mem_resp_error on word 1.
  - Required: fill_error pulse, no fill_we, miss_ready = 1 next cycle.
- Invalidate during refill:
  - Stimulus: invalidate_all asserted mid-refill.
  - Required: line write first, then 256 consecutive fill_we with indices 0..255, fill_line = 0; miss_ready low throughout.
- Simultaneous miss and invalidate in IDLE:
  - Required: flush first; the miss is accepted only after the flush completes.
- Reset mid-refill:
  - Stimulus: rst after request 0 is accepted.
  - Required: all outputs 0 while rst is high; a late response is ignored; no fill_we.
